// File: rtl/pipe_stage_reg.sv
// Purpose  : generic inter-stage pipeline register with valid/ready handshake, flush-to-bubble and NOP-forcing of control.
// Latency  : 1 cycle from in_xfer to out_valid on an empty stage; 1 beat/cycle sustained in both SKID modes.
// Backpres.: SKID=1 holds up to 2 beats and drives a registered in_ready; SKID=0 holds 1 beat with combinational in_ready.
//
// Ports:
//   Clk, Reset            rising-edge clock, synchronous active-high reset
//   flush                 squash every held beat (redirect); a beat accepted in the same cycle is dropped
//   in_valid/in_ready     upstream handshake, in_ctrl/in_data payload
//   out_valid/out_ready   downstream handshake, out_ctrl/out_data payload
//   stall_cnt             saturating count of cycles with out_valid & ~out_ready
//   bubble_cnt            saturating count of non-reset cycles with out_valid=0
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int STAT_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              rdy_q;
  logic [STAT_W-1:0] stall_q, stall_d;
  logic [STAT_W-1:0] bubble_q, bubble_d;

  logic valid;
  logic in_xfer;
  logic out_xfer;

  assign valid = (state_q != ST_EMPTY);

  // With SKID=1 the ready flop is the only source, so the upstream timing
  // path does not see out_ready. Reset gating keeps in_ready low while
  // Reset is held and lets it rise in the very first cycle after release.
  assign in_ready = ~Reset & ((SKID != 0) ? rdy_q : (out_ready | ~valid));

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = valid & out_ready;

  // The FULL state is only reachable when SKID=1: with SKID=0, in_ready in
  // ONE implies out_ready, so an accepted beat always replaces the main entry.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Main payload is left untouched so out_data keeps its last value.
      state_d     = ST_EMPTY;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            ctrl_d  = in_ctrl;
            data_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            ctrl_d = in_ctrl;
            data_d = in_data;
          end else if (in_xfer) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            ctrl_d  = skid_ctrl_q;
            data_d  = skid_data_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Saturating perf counters; they observe the current cycle's outputs.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (valid && !out_ready && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
    if (!valid && !(&bubble_q)) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_EMPTY;
      rdy_q       <= 1'b1;
      ctrl_q      <= '0;
      data_q      <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
      bubble_q    <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= (state_d != ST_FULL);
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
    end
  end

  assign out_valid  = valid;
  // An empty stage must look like a NOP so no enable leaks downstream.
  assign out_ctrl   = valid ? ctrl_q : '0;
  assign out_data   = data_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose  : self-checking bench for pipe_stage_reg, one SKID=1/STAT_W=4 and one SKID=0/STAT_W=16 instance on shared inputs.
// Latency  : outputs sampled at the falling edge and compared against a FIFO-level reference model each cycle.
// Backpres.: out_ready is driven directly by the directed steps and by the random phase.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [31:0] data;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_ctrl;
  logic [31:0] in_data;
  logic        out_ready;

  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_ctrl;
  logic [31:0] s_out_data;
  logic [3:0]  s_stall, s_bubble;

  logic        n_in_ready, n_out_valid;
  logic [15:0] n_out_ctrl;
  logic [31:0] n_out_data;
  logic [15:0] n_stall, n_bubble;

  int n_vec;
  int n_err;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .STAT_W(4)) u_skid (
    .Clk(clk), .Reset(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .stall_cnt(s_stall), .bubble_cnt(s_bubble)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .STAT_W(16)) u_noskid (
    .Clk(clk), .Reset(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_ctrl(n_out_ctrl), .out_data(n_out_data),
    .stall_cnt(n_stall), .bubble_cnt(n_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 = SKID=1 (capacity 2), index 1 = SKID=0 (capacity 1).
  beat_t       mf   [2][2];
  int          mcnt [2];
  logic [31:0] mlast[2];
  int          mstall[2];
  int          mbub [2];
  int          msat [2];

  logic        e_ov[2];
  logic [15:0] e_oc[2];
  logic [31:0] e_od[2];
  logic        e_ir[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_outputs();
    for (int i = 0; i < 2; i++) begin
      e_ov[i] = (mcnt[i] > 0);
      e_oc[i] = e_ov[i] ? mf[i][0].ctrl : 16'h0;
      e_od[i] = e_ov[i] ? mf[i][0].data : mlast[i];
    end
    e_ir[0] = !rst && (mcnt[0] < 2);
    e_ir[1] = !rst && (out_ready || (mcnt[1] == 0));
  endtask

  task automatic model_step();
    beat_t nb;
    logic  ix, ox;
    model_outputs();
    nb.ctrl = in_ctrl;
    nb.data = in_data;
    for (int i = 0; i < 2; i++) begin
      ix = in_valid && e_ir[i];
      ox = e_ov[i] && out_ready;
      if (rst) begin
        mcnt[i]   = 0;
        mlast[i]  = 32'h0;
        mstall[i] = 0;
        mbub[i]   = 0;
      end else begin
        if (e_ov[i] && !out_ready && mstall[i] < msat[i]) mstall[i]++;
        if (!e_ov[i] && mbub[i] < msat[i]) mbub[i]++;
        if (flush) begin
          mcnt[i] = 0;
        end else begin
          if (ox) begin
            mf[i][0] = mf[i][1];
            mcnt[i]--;
          end
          if (ix) begin
            mf[i][mcnt[i]] = nb;
            mcnt[i]++;
          end
        end
        if (mcnt[i] > 0) mlast[i] = mf[i][0].data;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_outputs();
    chk("skid.out_valid",   s_out_valid, e_ov[0]);
    chk("skid.out_ctrl",    s_out_ctrl,  e_oc[0]);
    chk("skid.out_data",    s_out_data,  e_od[0]);
    chk("skid.in_ready",    s_in_ready,  e_ir[0]);
    chk("skid.stall_cnt",   s_stall,     mstall[0]);
    chk("skid.bubble_cnt",  s_bubble,    mbub[0]);
    chk("noskid.out_valid", n_out_valid, e_ov[1]);
    chk("noskid.out_ctrl",  n_out_ctrl,  e_oc[1]);
    chk("noskid.out_data",  n_out_data,  e_od[1]);
    chk("noskid.in_ready",  n_in_ready,  e_ir[1]);
    chk("noskid.stall_cnt", n_stall,     mstall[1]);
    chk("noskid.bubble_cnt",n_bubble,    mbub[1]);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic beat(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = 16'h8000 | d[15:0];
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    msat[0] = 15;
    msat[1] = 65535;
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; mlast[i] = 32'h0; mstall[i] = 0; mbub[i] = 0;
    end

    // Reset held with in_valid asserted
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    beat(1'b1, 32'hDEAD);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("rst.skid_in_ready",   s_in_ready, 1'b0);
      chk("rst.noskid_in_ready", n_in_ready, 1'b0);
      chk("rst.out_valid",       s_out_valid, 1'b0);
      advance();
    end
    rst = 1'b0;
    beat(1'b0, 32'h0);
    sample();
    chk("post_rst.skid_in_ready", s_in_ready, 1'b1);
    chk("post_rst.out_ctrl",      s_out_ctrl, 16'h0);
    advance();

    // Streaming 0x1000..0x1007 with out_ready=1
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      beat(k < 8, 32'h1000 + k);
      sample();
      if (k > 0) begin
        chk("stream.skid_data",   s_out_data, 32'h1000 + k - 1);
        chk("stream.noskid_data", n_out_data, 32'h1000 + k - 1);
        chk("stream.skid_valid",  s_out_valid, 1'b1);
      end
      advance();
    end
    beat(1'b0, 32'h0);
    sample();
    chk("stream.stall_cnt", s_stall, 4'd0);
    advance();

    // Stall with SKID=1: 0xA then 0xB fill both entries
    out_ready = 1'b0;
    beat(1'b1, 32'hA);
    sample();
    chk("stall.rdy_first", s_in_ready, 1'b1);
    advance();
    beat(1'b1, 32'hB);
    sample();
    chk("stall.rdy_second", s_in_ready, 1'b1);
    advance();
    beat(1'b0, 32'h0);
    sample();
    chk("stall.rdy_full", s_in_ready, 1'b0);
    chk("stall.head",     s_out_data, 32'hA);
    advance();
    cycle();
    out_ready = 1'b1;
    sample();
    chk("release.first", s_out_data, 32'hA);
    advance();
    sample();
    chk("release.second", s_out_data, 32'hB);
    advance();
    cycle();

    // Flush while FULL with 0xC offered
    out_ready = 1'b0;
    beat(1'b1, 32'hA1);
    cycle();
    beat(1'b1, 32'hB1);
    cycle();
    beat(1'b1, 32'hC);
    flush = 1'b1;
    sample();
    chk("flush.rdy_in_full", s_in_ready, 1'b0);
    advance();
    flush = 1'b0;
    beat(1'b0, 32'h0);
    sample();
    chk("flush.out_valid", s_out_valid, 1'b0);
    chk("flush.out_ctrl",  s_out_ctrl,  16'h0);
    chk("flush.in_ready",  s_in_ready,  1'b1);
    chk("flush.data_held", s_out_data,  32'hA1);
    advance();
    out_ready = 1'b1;
    cycle();
    cycle();

    // Counter saturation on the 4-bit instance
    out_ready = 1'b0;
    beat(1'b1, 32'h500);
    cycle();
    beat(1'b0, 32'h0);
    for (int k = 0; k < 20; k++) cycle();
    sample();
    chk("sat.stall_cnt", s_stall, 4'hF);
    advance();

    // SKID=0: combinational in_ready and bubble-free replacement
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    out_ready = 1'b0;
    beat(1'b1, 32'h600);
    cycle();
    beat(1'b0, 32'h0);
    sample();
    chk("noskid.rdy_stalled", n_in_ready, 1'b0);
    chk("noskid.held",        n_out_data, 32'h600);
    out_ready = 1'b1;
    beat(1'b1, 32'h601);
    #1;
    chk("noskid.rdy_comb", n_in_ready, 1'b1);
    advance();
    beat(1'b0, 32'h0);
    sample();
    chk("noskid.replace_valid", n_out_valid, 1'b1);
    chk("noskid.replace_data",  n_out_data,  32'h601);
    advance();

    // Randomised traffic including flush and mid-run reset
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = 16'($urandom);
      in_data   = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
